// File: rtl/line_buffer_window_pkg.sv
// line_buffer_window_pkg: shared state encoding and default sizes for the window generator
package line_buffer_window_pkg;
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int DEF_KERNEL_SIZE = 3;
endpackage

// File: rtl/line_buffer_row.sv
// line_buffer_row: one image row of storage, registered read, read-before-write on a shared address
module line_buffer_row #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 640
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/line_buffer_window.sv
// line_buffer_window: streams raster pixels into a KxK sliding window with stride and handshakes
module line_buffer_window
    import line_buffer_window_pkg::*;
#(
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int STRIDE       = 1
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [PIXEL_WIDTH-1:0]                          pixel_in,
    input  logic                                            pixel_valid,
    output logic                                            pixel_ready,
    input  logic                                            frame_start,
    output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] window_out,
    output logic                                            window_valid,
    input  logic                                            window_ready,
    output logic [$clog2(IMAGE_WIDTH)-1:0]                  window_x,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]                 window_y,
    output logic                                            frame_done
);
    localparam int K = KERNEL_SIZE;
    localparam int XW = $clog2(IMAGE_WIDTH);
    localparam int YW = $clog2(IMAGE_HEIGHT);
    localparam int LAST_X = IMAGE_WIDTH - 1 - ((IMAGE_WIDTH - K) % STRIDE);
    localparam int LAST_Y = IMAGE_HEIGHT - 1 - ((IMAGE_HEIGHT - K) % STRIDE);

    state_t state, state_nxt;
    logic [XW-1:0] col, col_nxt, ec;
    logic [YW-1:0] row, row_nxt, er;
    logic acc, take, eol, eof, qual;
    logic [K-1:0][K-1:0][PIXEL_WIDTH-1:0] win;
    logic [K-1:0][PIXEL_WIDTH-1:0] col_in;
    logic [K-2:0][PIXEL_WIDTH-1:0] rd, wdata;

    assign pixel_ready = !window_valid || window_ready;
    assign acc = pixel_valid && pixel_ready;
    // a frame_start pixel is always coordinate (0,0), whatever the counters say
    assign ec = frame_start ? '0 : col;
    assign er = frame_start ? '0 : row;
    assign eol = ec == XW'(IMAGE_WIDTH - 1);
    assign eof = eol && er == YW'(IMAGE_HEIGHT - 1);
    assign qual = take && int'(ec) >= K - 1 && int'(er) >= K - 1 &&
                  (int'(ec) - (K - 1)) % STRIDE == 0 && (int'(er) - (K - 1)) % STRIDE == 0;
    // line buffers read one column ahead so their output lines up with the next accepted pixel
    assign col_nxt = reset ? '0 : !take ? col : eol ? '0 : ec + 1'b1;
    assign row_nxt = reset ? '0 : !take ? row : !eol ? er : eof ? '0 : er + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb state_nxt = !acc ? state : frame_start ? ACTIVE : eof ? IDLE : state;

    always_comb take = acc && (frame_start || state == ACTIVE);

    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            window_valid <= 1'b0;
            window_x <= '0;
            window_y <= '0;
            win <= '0;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
            if (pixel_ready) window_valid <= qual;
            if (qual) begin
                window_x <= ec;
                window_y <= er;
            end
            if (take)
                for (int n = 0; n < K; n++)
                    win[n] <= {col_in[n], win[n][K-1:1]};
        end
    end

    assign wdata[0] = pixel_in;
    assign col_in[K-1] = pixel_in;
    genvar i;
    generate
        for (i = 0; i < K - 1; i++) begin : g_row
            line_buffer_row #(.WIDTH(PIXEL_WIDTH), .DEPTH(IMAGE_WIDTH)) u_row (
                .clock  (clock),
                .wr_en  (take),
                .wr_addr(ec),
                .wr_data(wdata[i]),
                .rd_addr(col_nxt),
                .rd_data(rd[i])
            );
            assign col_in[i] = rd[K-2-i];
            if (i > 0) begin : g_chain
                assign wdata[i] = rd[i-1];
            end
        end
    endgenerate

    assign window_out = win;
    assign frame_done = window_valid && window_ready &&
                        int'(window_x) == LAST_X && int'(window_y) == LAST_Y;
endmodule

// File: tb/tb_line_buffer_window.sv
// tb_line_buffer_window: randomized and directed checks against a full-frame window model
module tb_line_buffer_window;
    localparam int W = 8, H = 6, K = 3;

    typedef struct {
        logic [71:0] w;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        last;
        int          seq;
    } exp_t;

    logic clock = 0, reset = 1;
    logic [7:0] pixel_in = 0;
    logic pixel_valid = 0, frame_start = 0, window_ready = 1;
    logic pixel_ready, window_valid, frame_done;
    logic [71:0] window_out;
    logic [2:0] window_x, window_y;
    logic pixel_ready2, window_valid2, frame_done2;
    logic [71:0] window_out2;
    logic [2:0] window_x2, window_y2;

    int checks = 0, passes = 0;
    int wins1, wins2, fd1, fd2, acc_total, p;
    bit active, chk_lat, chk2, done;
    logic [7:0] img [H][W];
    exp_t q1[$], q2[$], e1, e2;
    int xfer_acc[$];
    logic [71:0] first_w, exp229;
    logic [5:0] fdxy2;

    line_buffer_window #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KERNEL_SIZE(K), .STRIDE(1)) dut (
        .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .frame_start(frame_start), .window_out(window_out),
        .window_valid(window_valid), .window_ready(window_ready), .window_x(window_x),
        .window_y(window_y), .frame_done(frame_done));

    line_buffer_window #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KERNEL_SIZE(K), .STRIDE(2)) dut2 (
        .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready2), .frame_start(frame_start), .window_out(window_out2),
        .window_valid(window_valid2), .window_ready(window_ready), .window_x(window_x2),
        .window_y(window_y2), .frame_done(frame_done2));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // reference: keep the whole frame, cut every qualifying KxK block out of it
    task automatic model_accept(input logic [7:0] pix, input logic fs);
        int c, r;
        exp_t e;
        if (fs) begin
            active = 1;
            p = 0;
        end
        if (!active) return;
        c = p % W;
        r = p / W;
        img[r][c] = pix;
        for (int s = 1; s <= 2; s++) begin
            if (c >= K - 1 && r >= K - 1 && (c - K + 1) % s == 0 && (r - K + 1) % s == 0) begin
                for (int n = 0; n < K; n++)
                    for (int m = 0; m < K; m++)
                        e.w[8*(m+K*n) +: 8] = img[r-K+1+n][c-K+1+m];
                e.x = 3'(c);
                e.y = 3'(r);
                e.last = c == W - 1 - (W - K) % s && r == H - 1 - (H - K) % s;
                e.seq = acc_total + 1;
                if (s == 1) q1.push_back(e);
                else if (chk2) q2.push_back(e);
            end
        end
        p++;
        if (p == W * H) active = 0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (window_valid && window_ready) begin
                if (xfer_acc.size() == 0) first_w = window_out;
                xfer_acc.push_back(acc_total);
                wins1++;
                check("win_pending", q1.size() != 0, 1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    check("win_data", window_out, e1.w);
                    check("win_xy", {window_x, window_y}, {e1.x, e1.y});
                    check("win_done", frame_done, e1.last);
                    if (chk_lat) check("win_latency", acc_total, e1.seq);
                end
            end else if (frame_done) check("done_stray", frame_done, 0);
            if (frame_done) fd1++;
            if (chk2 && window_valid2 && window_ready) begin
                wins2++;
                check("s2_pending", q2.size() != 0, 1);
                if (q2.size() != 0) begin
                    e2 = q2.pop_front();
                    check("s2_data", window_out2, e2.w);
                    check("s2_xy", {window_x2, window_y2}, {e2.x, e2.y});
                    check("s2_done", frame_done2, e2.last);
                end
            end
            if (frame_done2) begin
                fd2++;
                fdxy2 = {window_x2, window_y2};
            end
            if (pixel_valid && pixel_ready) begin
                model_accept(pixel_in, frame_start);
                acc_total++;
            end
        end
    end

    task automatic do_reset();
        reset = 1;
        pixel_valid = 0;
        frame_start = 0;
        window_ready = 1;
        repeat (2) begin @(posedge clock); #1; end
        q1.delete(); q2.delete(); xfer_acc.delete();
        active = 0; p = 0; acc_total = 0;
        wins1 = 0; wins2 = 0; fd1 = 0; fd2 = 0;
        reset = 0;
    endtask

    task automatic idle(input int n);
        pixel_valid = 0;
        frame_start = 0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic send(input logic [7:0] pix, input logic fs, input int gap);
        int t = 0;
        logic ok = 0;
        if (gap > 0) idle(gap);
        pixel_in = pix;
        frame_start = fs;
        pixel_valid = 1;
        while (!ok && t < 1000) begin
            @(negedge clock);
            ok = pixel_ready;
            @(posedge clock); #1;
            t++;
        end
        if (!ok) check("accept_timeout", ok, 1);
        pixel_valid = 0;
        frame_start = 0;
    endtask

    task automatic send_frame(input bit rnd);
        int g;
        for (int i = 0; i < W * H; i++) begin
            g = 0;
            if (rnd) while ($urandom_range(0, 1) == 1) g++;
            send(rnd ? 8'($urandom) : 8'(i), i == 0, g);
        end
    endtask

    task automatic stall_at(input int x, input int y);
        int t = 0;
        logic [71:0] w0;
        while (!(window_valid && window_x == 3'(x) && window_y == 3'(y)) && t < 300) begin
            @(posedge clock); #1;
            t++;
        end
        if (t >= 300) check("stall_timeout", t, 0);
        window_ready = 0;
        w0 = window_out;
        repeat (5) begin
            @(negedge clock);
            check("stall_ready", pixel_ready, 0);
            check("stall_win", window_out, w0);
            check("stall_xy", {window_x, window_y}, {3'(x), 3'(y)});
        end
        @(posedge clock); #1;
        window_ready = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int vals[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        for (int i = 0; i < 9; i++) exp229[8*i +: 8] = 8'(vals[i]);
        do_reset();
        @(negedge clock);
        check("rst_valid", window_valid, 0);
        check("rst_ready", pixel_ready, 1);
        check("rst_out", window_out, 0);
        check("rst_xy", {window_x, window_y}, 0);
        check("rst_done", frame_done, 0);

        chk_lat = 1; chk2 = 1;
        @(posedge clock); #1;
        send_frame(0);
        idle(4);
        check("ramp_count", wins1, 24);
        check("ramp_first_acc", xfer_acc.size() > 0 ? xfer_acc[0] : -1, 19);
        check("ramp_first_win", first_w, exp229);
        check("ramp_done", fd1, 1);
        check("ramp_drain", q1.size(), 0);
        check("s2_count", wins2, 6);
        check("s2_done_cnt", fd2, 1);
        check("s2_done_xy", fdxy2, {3'd6, 3'd4});
        check("s2_drain", q2.size(), 0);
        chk2 = 0;

        do_reset();
        chk_lat = 0;
        fork
            send_frame(0);
            stall_at(4, 3);
        join
        idle(4);
        check("stall_count", wins1, 24);
        check("stall_done", fd1, 1);
        check("stall_drain", q1.size(), 0);

        do_reset();
        chk_lat = 1;
        for (int i = 0; i < 20; i++) send(8'(i), i == 0, 0);
        reset = 1;
        @(posedge clock); #1;
        check("rst_mid_valid", window_valid, 0);
        do_reset();
        for (int i = 0; i < 10; i++) send(8'(100 + i), 0, 0);
        idle(4);
        check("drop_count", wins1, 0);
        check("drop_valid", window_valid, 0);
        send_frame(0);
        idle(4);
        check("refresh_count", wins1, 24);
        check("refresh_first_acc", xfer_acc.size() > 0 ? xfer_acc[0] : -1, 29);
        check("refresh_done", fd1, 1);

        do_reset();
        for (int i = 0; i < 30; i++) send(8'(i), i == 0, 0);
        send_frame(0);
        idle(4);
        check("restart_count", wins1, 34);
        check("restart_first_acc", xfer_acc.size() > 10 ? xfer_acc[10] : -1, 49);
        check("restart_done", fd1, 1);

        do_reset();
        chk_lat = 0;
        done = 0;
        fork
            begin
                repeat (3) send_frame(1);
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clock); #1;
                    window_ready = 1'($urandom);
                end
                window_ready = 1;
            end
        join
        idle(10);
        check("rand_count", wins1, 72);
        check("rand_done", fd1, 3);
        check("rand_drain", q1.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
